// File: rtl/mpu_matrix_loader_pkg.sv
// Shared constants, state encoding and layout helper
// for the MPU operand loader.
package mpu_matrix_loader_pkg;

    localparam int DIM            = 5;
    localparam int ELEM_W         = 8;
    localparam int COMPUTE_CYCLES = 5;
    localparam int MAT_W          = ELEM_W * DIM * DIM;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        COMPUTE = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Bit offset of element (r,c) in a flattened row-major matrix.
    function automatic int elem_off(input int r, input int c,
                                    input int dim, input int ew);
        return ew * (c + dim * r);
    endfunction

endpackage

// File: rtl/mpu_matrix_loader_if.sv
// Element stream into the loader: valid/ready handshake
// carrying one signed element per accepted beat.
interface mpu_matrix_loader_if
    import mpu_matrix_loader_pkg::*;
#(
    parameter int EW = ELEM_W
);

    logic [EW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/mpu_matrix_loader_index.sv
// Row/column write pointer for a size x size row-major
// fill, with wrap at the active size and a last-element flag.
module mpu_index_counter (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] size,
    output logic [7:0] row,
    output logic [7:0] col,
    output logic       last
);

    logic col_end;

    assign col_end = (col == size - 8'd1);
    assign last    = col_end && (row == size - 8'd1);

    // Advance column per beat, roll into the next row at the edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            if (col_end) begin
                col <= '0;
                row <= row + 8'd1;
            end else begin
                col <= col + 8'd1;
            end
        end
    end

endmodule

// File: rtl/mpu_matrix_loader.sv
// Loads operand matrices A then B from an element stream
// and holds them stable for a fixed MPU compute window.
module mpu_matrix_loader
    import mpu_matrix_loader_pkg::*;
#(
    parameter int DIM            = mpu_matrix_loader_pkg::DIM,
    parameter int ELEM_W         = mpu_matrix_loader_pkg::ELEM_W,
    parameter int COMPUTE_CYCLES = mpu_matrix_loader_pkg::COMPUTE_CYCLES
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [7:0]                size_in,
    mpu_matrix_loader_if.slave        in_if,
    output logic [ELEM_W*DIM*DIM-1:0] matrix_a,
    output logic [ELEM_W*DIM*DIM-1:0] matrix_b,
    output logic [7:0]                size,
    output logic                      busy,
    output logic                      operands_valid,
    output logic                      done,
    output logic                      error
);

    localparam int CW = $clog2(COMPUTE_CYCLES + 1);

    state_t            state;
    state_t            state_nx;
    logic              ready;
    logic              beat;
    logic              size_ok;
    logic              accept;
    logic              reject;
    logic              last;
    logic              cyc_last;
    logic [7:0]        row;
    logic [7:0]        col;
    logic [CW-1:0]     cyc;
    logic [ELEM_W-1:0] a_q [DIM][DIM];
    logic [ELEM_W-1:0] b_q [DIM][DIM];

    assign in_if.in_ready = ready;
    assign beat     = in_if.in_valid & ready;
    assign size_ok  = (size_in != 8'd0) && (size_in <= 8'(DIM));
    assign accept   = (state == IDLE) && start && size_ok;
    assign reject   = (state == IDLE) && start && !size_ok;
    assign cyc_last = (cyc == CW'(COMPUTE_CYCLES - 1));

    mpu_index_counter u_idx (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (beat),
        .clr     (accept | (beat & last)),
        .size    (size),
        .row     (row),
        .col     (col),
        .last    (last)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_nx       = state;
        ready          = 1'b0;
        busy           = 1'b1;
        operands_valid = 1'b0;
        done           = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) state_nx = LOAD_A;
            end
            LOAD_A: begin
                ready = 1'b1;
                if (beat && last) state_nx = LOAD_B;
            end
            LOAD_B: begin
                ready = 1'b1;
                if (beat && last) state_nx = COMPUTE;
            end
            COMPUTE: begin
                operands_valid = 1'b1;
                if (cyc_last) state_nx = DONE;
            end
            DONE: begin
                operands_valid = 1'b1;
                done           = 1'b1;
                state_nx       = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Compute-window cycle counter, idle at zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cyc <= '0;
        end else if (state == COMPUTE && !cyc_last) begin
            cyc <= cyc + CW'(1);
        end else begin
            cyc <= '0;
        end
    end

    // Latched size and rejected-start pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            size  <= '0;
            error <= 1'b0;
        end else begin
            error <= reject;
            if (accept) size <= size_in;
        end
    end

    // Operand storage: clear on accepted start, write on each beat.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    a_q[r][c] <= '0;
                    b_q[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    a_q[r][c] <= '0;
                    b_q[r][c] <= '0;
                end
            end
        end else if (beat) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    if (row == 8'(r) && col == 8'(c)) begin
                        if (state == LOAD_A) a_q[r][c] <= in_if.in_data;
                        else                 b_q[r][c] <= in_if.in_data;
                    end
                end
            end
        end
    end

    for (genvar r = 0; r < DIM; r++) begin : g_row
        for (genvar c = 0; c < DIM; c++) begin : g_col
            assign matrix_a[elem_off(r, c, DIM, ELEM_W) +: ELEM_W] = a_q[r][c];
            assign matrix_b[elem_off(r, c, DIM, ELEM_W) +: ELEM_W] = b_q[r][c];
        end
    end

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Self-checking bench for mpu_matrix_loader: directed
// sequences, a reject table and randomized operand loads.
module tb_mpu_matrix_loader;
    import mpu_matrix_loader_pkg::*;

    localparam int MW = MAT_W;

    typedef struct {
        int sz;
        int err;
        int bsy;
    } vec_t;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    size_in = '0;
    logic [MW-1:0] matrix_a;
    logic [MW-1:0] matrix_b;
    logic [7:0]    size;
    logic          busy;
    logic          operands_valid;
    logic          done;
    logic          error;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            qa [DIM*DIM];
    int            qb [DIM*DIM];
    logic [MW-1:0] last_a = '0;
    logic [MW-1:0] last_b = '0;
    vec_t          tbl [5];

    mpu_matrix_loader_if #(.EW(ELEM_W)) bus ();

    mpu_matrix_loader dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .size_in        (size_in),
        .in_if          (bus),
        .matrix_a       (matrix_a),
        .matrix_b       (matrix_b),
        .size           (size),
        .busy           (busy),
        .operands_valid (operands_valid),
        .done           (done),
        .error          (error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkm(input string nm, input logic [MW-1:0] act,
                        input logic [MW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected flattened matrix for the first n*n stream values.
    function automatic logic [MW-1:0] model(input int q [DIM*DIM],
                                            input int n, input int cnt);
        logic [MW-1:0] m;
        m = '0;
        for (int k = 0; k < cnt; k++)
            m[ELEM_W*((k % n) + DIM*(k / n)) +: ELEM_W] = ELEM_W'(q[k]);
        return m;
    endfunction

    task automatic chk_idle_zero(input string nm);
        chk({nm, " busy"}, int'(busy), 0);
        chk({nm, " in_ready"}, int'(bus.in_ready), 0);
        chk({nm, " opv"}, int'(operands_valid), 0);
        chk({nm, " done"}, int'(done), 0);
        chk({nm, " error"}, int'(error), 0);
        chk({nm, " size"}, int'(size), 0);
        chkm({nm, " A"}, matrix_a, '0);
        chkm({nm, " B"}, matrix_b, '0);
    endtask

    // One full operation: start, stream A then B, observe compute window.
    task automatic run_op(input string nm, input int n, input int vmode,
                          input bit poke);
        int            total;
        int            idx;
        int            cyc;
        int            rdy_bad;
        int            ov;
        int            dn;
        int            ra;
        bit            v;
        logic [MW-1:0] ea;
        logic [MW-1:0] eb;
        ea = model(qa, n, n*n);
        eb = model(qb, n, n*n);
        @(negedge clock);
        start   = 1'b1;
        size_in = 8'(n);
        @(negedge clock);
        start   = 1'b0;
        total   = 2*n*n;
        idx     = 0;
        cyc     = 0;
        rdy_bad = 0;
        while (idx < total && cyc < 1000) begin
            if (bus.in_ready !== 1'b1) rdy_bad++;
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.in_valid = v;
            if (v)
                bus.in_data = ELEM_W'(idx < n*n ? qa[idx] : qb[idx-n*n]);
            else
                bus.in_data = ELEM_W'($urandom);
            start   = poke && idx >= n*n && (cyc % 3 == 0);
            size_in = 8'(n % DIM + 1);
            if (v) idx++;
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        chk({nm, " beats"}, idx, total);
        chk({nm, " ready during load"}, rdy_bad, 0);
        ov = 0;
        dn = 0;
        ra = 0;
        for (int k = 0; k < 40 && busy; k++) begin
            ov += int'(operands_valid);
            dn += int'(done);
            ra += int'(bus.in_ready);
            bus.in_valid = 1'b1;
            bus.in_data  = ELEM_W'($urandom);
            start        = poke && k == 2;
            @(negedge clock);
        end
        start        = 1'b0;
        bus.in_valid = 1'b0;
        chk({nm, " opv cycles"}, ov, COMPUTE_CYCLES + 1);
        chk({nm, " done pulses"}, dn, 1);
        chk({nm, " ready after load"}, ra, 0);
        chk({nm, " back to idle"}, int'(busy), 0);
        chk({nm, " size"}, int'(size), n);
        chkm({nm, " A"}, matrix_a, ea);
        chkm({nm, " B"}, matrix_b, eb);
        last_a = ea;
        last_b = eb;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        #1;
        chk_idle_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < DIM*DIM; i++) begin
            qa[i] = i + 1;
            qb[i] = (i / DIM == i % DIM) ? 1 : 0;
        end
        run_op("full5", 5, 0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            qa[i] = i + 1;
            qb[i] = -(i + 1);
        end
        run_op("size2", 2, 0, 1'b0);

        tbl[0] = '{0, 1, 0};
        tbl[1] = '{6, 1, 0};
        tbl[2] = '{255, 1, 0};
        tbl[3] = '{7, 1, 0};
        tbl[4] = '{3, 0, 1};
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            start        = 1'b1;
            size_in      = 8'(tbl[i].sz);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h55;
            @(negedge clock);
            start        = 1'b0;
            bus.in_valid = 1'b0;
            chk($sformatf("tbl%0d error", i), int'(error), tbl[i].err);
            chk($sformatf("tbl%0d busy", i), int'(busy), tbl[i].bsy);
            chk($sformatf("tbl%0d ready", i), int'(bus.in_ready), tbl[i].bsy);
            @(negedge clock);
            chk($sformatf("tbl%0d error once", i), int'(error), 0);
            chkm($sformatf("tbl%0d A", i), matrix_a,
                 tbl[i].bsy != 0 ? '0 : last_a);
            if (tbl[i].bsy != 0) begin
                reset_n = 1'b0;
                #1;
                chk_idle_zero($sformatf("tbl%0d abort", i));
                @(negedge clock);
                reset_n = 1'b1;
                last_a  = '0;
                last_b  = '0;
            end
        end

        for (int i = 0; i < 9; i++) begin
            qa[i] = int'($urandom_range(0, 255)) - 128;
            qb[i] = int'($urandom_range(0, 255)) - 128;
        end
        run_op("toggle3", 3, 1, 1'b0);

        for (int i = 0; i < DIM*DIM; i++) qa[i] = i + 1;
        @(negedge clock);
        start   = 1'b1;
        size_in = 8'd5;
        @(negedge clock);
        start        = 1'b0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.in_data = ELEM_W'(qa[k]);
            @(negedge clock);
        end
        bus.in_valid = 1'b0;
        chkm("partial A", matrix_a, model(qa, 5, 10));
        #2;
        reset_n = 1'b0;
        #1;
        chk_idle_zero("midload reset");
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("no done after abort", int'(done), 0);
        end
        qa[0] = -7;
        qb[0] = 99;
        run_op("size1", 1, 0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            qa[i] = int'($urandom_range(0, 255)) - 128;
            qb[i] = int'($urandom_range(0, 255)) - 128;
        end
        run_op("poke4", 4, 0, 1'b1);

        for (int t = 0; t < 6; t++) begin
            int n;
            n = int'($urandom_range(1, DIM));
            for (int i = 0; i < n*n; i++) begin
                qa[i] = int'($urandom_range(0, 255)) - 128;
                qb[i] = int'($urandom_range(0, 255)) - 128;
            end
            run_op($sformatf("rand%0d", t), n, 2, t[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
